alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001: clk  input  1  sole clock; all state updates on rising edge.
REQ-002: rst  input  1  reset, asynchronous, active-high.
REQ-003: in_valid  input  1  upstream instruction valid.
REQ-004: in_ready  output  1  stage can accept an instruction this cycle.
REQ-005: instr  input  32  RV32I instruction word, sampled when in_valid & in_ready.
REQ-006: flush  input  1  discard all held and in-flight entries.
REQ-007: out_valid  output  1  decoded entry valid.
REQ-008: out_ready  input  1  ALU stage accepts the entry this cycle.
REQ-009: alu_ctrl  output  5  ALU operation, ALUCTRL_* encodings from the shared ALU control definitions.
REQ-010: alu_src  output  1  second operand select: 0 = rs2 data, 1 = imm.
REQ-011: imm  output  32  sign-extended immediate.
REQ-012: rs1, rs2, rd  output  5 each  register indices taken from instr[19:15], instr[24:20] and instr[11:7].
REQ-013: illegal  output  1  opcode/funct combination not decodable.

Function
REQ-014: Transfer in: in_valid & in_ready; transfer out: out_valid & out_ready; outputs shall be registered, latency exactly 1 cycle from accept to out_valid.
REQ-015: Outputs shall hold stable while out_valid & ~out_ready.
REQ-016: R-type (0110011) decode: funct3/instr[30] -> ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; alu_src = 0; imm = 0.
REQ-017: OP-IMM (0010011) decode: same ops except no SUB, SRAI selected by instr[30]; alu_src = 1; I-immediate.
REQ-018: LOAD (0000011), JALR (1100111) -> ADD with I-immediate; STORE (0100011) -> ADD with S-immediate; alu_src = 1 for all three.
REQ-019: BRANCH (1100011) funct3 -> BEQ, BNE, BLT, BGE, BLTU, BGEU; alu_src = 0; B-immediate (bit 0 = 0).
REQ-020: LUI, AUIPC -> ADD with U-immediate; JAL -> ADD with J-immediate; alu_src = 1 for all three.
REQ-021: Any other opcode, R-type funct7 other than 0000000/0100000, or branch funct3 010/011 shall yield illegal = 1, alu_ctrl = ADD, alu_src = 0, imm = 0; the entry still flows (not dropped).
REQ-022: flush shall clear all entries next edge; flush has priority over a simultaneous accept, which is discarded.
REQ-023: Simultaneous accept and drain when holding one entry shall keep occupancy constant with no bubble.

Reset
REQ-024: While rst is high: out_valid = 0, illegal = 0, alu_ctrl = ADD, alu_src = 0, imm = 0, rs1 = rs2 = rd = 0, all entries empty; in_ready = 1 from the first cycle after rst deasserts.
REQ-025: Reset asserted mid-transfer shall drop the entry with no partial output.

Configuration
REQ-026: Macro DECODE_SKID_EN defined: two-entry skid buffer (main + skid); in_ready is a register equal to "skid entry empty"; on out_ready low with an accept, the new entry goes to skid; full throughput without combinational ready path.
REQ-027: DECODE_SKID_EN undefined: single register; in_ready = ~out_valid | out_ready (combinational); all other behaviour identical.

Verification
REQ-028: instr 0x00500093 (addi x1,x0,5), out_ready = 1 -> next cycle out_valid = 1, alu_ctrl = ADD, alu_src = 1, imm = 0x00000005, rd = 1, illegal = 0.
REQ-029: instr 0x402081B3 (sub x3,x1,x2) -> alu_ctrl = SUB, alu_src = 0, rs1 = 1, rs2 = 2, rd = 3.
REQ-030: instr 0xFE208EE3 (beq x1,x2,-4) -> alu_ctrl = BEQ, alu_src = 0, imm = 0xFFFFFFFC; instr 0x40335293 (srai x5,x6,3) -> SRA, alu_src = 1, imm[4:0] = 3.
REQ-031: Stream 4 instructions with out_ready low for cycles 2-4 -> no loss or duplication, output order preserved, outputs stable while stalled; with DECODE_SKID_EN in_ready drops only after the second held entry.
REQ-032: instr 0xFFFFFFFF -> illegal = 1, alu_ctrl = ADD, imm = 0; flush asserted with in_valid = 1 while holding an entry -> out_valid = 0 next cycle.
REQ-033: rst pulsed asynchronously mid-stream -> out_valid falls immediately, all outputs at REQ-024 values, decode resumes correctly after release.

Source files
------------

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I decode into ALU control, operand select and immediate,
// behind a valid/ready register slice. Define DECODE_SKID_EN for a two-entry
// skid buffer with a registered in_ready; otherwise a single output register
// with a combinational in_ready.

package alu_decode_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_ADD  = 5'd0;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_SUB  = 5'd1;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_SLL  = 5'd2;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_SLT  = 5'd3;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_SLTU = 5'd4;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_XOR  = 5'd5;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_SRL  = 5'd6;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_SRA  = 5'd7;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_OR   = 5'd8;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_AND  = 5'd9;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_BEQ  = 5'd10;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_BNE  = 5'd11;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_BLT  = 5'd12;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_BGE  = 5'd13;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_BLTU = 5'd14;
  localparam logic [ALU_CTRL_W-1:0] ALUCTRL_BGEU = 5'd15;

  typedef struct packed {
    logic                  illegal;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_src;
    logic [XLEN-1:0]       imm;
    logic [REG_W-1:0]      rs1;
    logic [REG_W-1:0]      rs2;
    logic [REG_W-1:0]      rd;
  } dec_entry_t;

  localparam dec_entry_t DEC_RESET = '{illegal: 1'b0, alu_ctrl: ALUCTRL_ADD,
                                       alu_src: 1'b0, imm: '0,
                                       rs1: '0, rs2: '0, rd: '0};
endpackage

module alu_decode_stage
  import alu_decode_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       instr,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  alu_src,
  output logic [XLEN-1:0]       imm,
  output logic [REG_W-1:0]      rs1,
  output logic [REG_W-1:0]      rs2,
  output logic [REG_W-1:0]      rd,
  output logic                  illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // Shared funct3 -> arithmetic op map for OP and OP-IMM.
  function automatic logic [ALU_CTRL_W-1:0] arith_op(input logic [2:0] f3,
                                                      input logic sub_sel,
                                                      input logic sra_sel);
    case (f3)
      3'b000:  arith_op = sub_sel ? ALUCTRL_SUB : ALUCTRL_ADD;
      3'b001:  arith_op = ALUCTRL_SLL;
      3'b010:  arith_op = ALUCTRL_SLT;
      3'b011:  arith_op = ALUCTRL_SLTU;
      3'b100:  arith_op = ALUCTRL_XOR;
      3'b101:  arith_op = sra_sel ? ALUCTRL_SRA : ALUCTRL_SRL;
      3'b110:  arith_op = ALUCTRL_OR;
      default: arith_op = ALUCTRL_AND;
    endcase
  endfunction

  // Full decode of one instruction word; anything unrecognised stays illegal/ADD/imm 0.
  function automatic dec_entry_t decode(input logic [XLEN-1:0] i);
    dec_entry_t d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = i[31:25];
    f3 = i[14:12];
    d = DEC_RESET;
    d.illegal = 1'b1;
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.rd  = i[11:7];
    case (i[6:0])
      OPC_OP: begin
        if (f7 == 7'b0000000) begin
          d.illegal  = 1'b0;
          d.alu_ctrl = arith_op(f3, 1'b0, 1'b0);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          d.illegal  = 1'b0;
          d.alu_ctrl = arith_op(f3, 1'b1, 1'b1);
        end
      end
      OPC_OP_IMM: begin
        d.illegal  = 1'b0;
        d.alu_ctrl = arith_op(f3, 1'b0, i[30]);
        d.alu_src  = 1'b1;
        d.imm      = {{20{i[31]}}, i[31:20]};
      end
      OPC_LOAD, OPC_JALR: begin
        d.illegal = 1'b0;
        d.alu_src = 1'b1;
        d.imm     = {{20{i[31]}}, i[31:20]};
      end
      OPC_STORE: begin
        d.illegal = 1'b0;
        d.alu_src = 1'b1;
        d.imm     = {{20{i[31]}}, i[31:25], i[11:7]};
      end
      OPC_BRANCH: begin
        if (f3 != 3'b010 && f3 != 3'b011) begin
          d.illegal = 1'b0;
          d.imm     = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
          case (f3)
            3'b000:  d.alu_ctrl = ALUCTRL_BEQ;
            3'b001:  d.alu_ctrl = ALUCTRL_BNE;
            3'b100:  d.alu_ctrl = ALUCTRL_BLT;
            3'b101:  d.alu_ctrl = ALUCTRL_BGE;
            3'b110:  d.alu_ctrl = ALUCTRL_BLTU;
            default: d.alu_ctrl = ALUCTRL_BGEU;
          endcase
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        d.illegal = 1'b0;
        d.alu_src = 1'b1;
        d.imm     = {i[31:12], 12'b0};
      end
      OPC_JAL: begin
        d.illegal = 1'b0;
        d.alu_src = 1'b1;
        d.imm     = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      end
      default: ;
    endcase
    return d;
  endfunction

  dec_entry_t dec_c;
  dec_entry_t main_q, main_d;
  logic       main_valid_q, main_valid_d;
  logic       accept_c;

  assign dec_c    = decode(instr);
  assign accept_c = in_valid & in_ready;

`ifdef DECODE_SKID_EN
  dec_entry_t skid_q, skid_d;
  logic       skid_valid_q, skid_valid_d;
  logic       in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  // Main slot refills from skid first; new entries park in skid while main is stalled.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        main_d       = dec_c;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_d       = dec_c;
      skid_valid_d = 1'b1;
    end
    in_ready_d = ~skid_valid_d;
  end

  // State registers; reset empties both slots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= DEC_RESET;
      main_valid_q <= 1'b0;
      skid_q       <= DEC_RESET;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = ~main_valid_q | out_ready;

  // Single slot: load on accept, empty on drain, flush wins over accept.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
    end else if (accept_c) begin
      main_d       = dec_c;
      main_valid_d = 1'b1;
    end else if (out_ready) begin
      main_valid_d = 1'b0;
    end
  end

  // State registers; reset empties the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= DEC_RESET;
      main_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
    end
  end
`endif

  assign out_valid = main_valid_q;
  assign illegal   = main_q.illegal;
  assign alu_ctrl  = main_q.alu_ctrl;
  assign alu_src   = main_q.alu_src;
  assign imm       = main_q.imm;
  assign rs1       = main_q.rs1;
  assign rs2       = main_q.rs2;
  assign rd        = main_q.rd;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode table, stall/order sequence,
// flush and asynchronous reset corners.
module tb_alu_decode_stage;

  localparam logic [4:0] C_ADD  = 5'd0;
  localparam logic [4:0] C_SUB  = 5'd1;
  localparam logic [4:0] C_SLTU = 5'd4;
  localparam logic [4:0] C_XOR  = 5'd5;
  localparam logic [4:0] C_SRA  = 5'd7;
  localparam logic [4:0] C_BEQ  = 5'd10;
  localparam logic [4:0] C_BGEU = 5'd15;
  localparam int NVEC = 17;

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic [4:0]  ctrl;
    logic        src;
    logic [31:0] imm;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic        alu_src, illegal;
  logic [31:0] instr, imm;
  logic [4:0]  alu_ctrl, rs1, rs2, rd;
  logic [53:0] act;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[NVEC];

  alu_decode_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .imm(imm), .rs1(rs1), .rs2(rs2),
    .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign act = {illegal, alu_ctrl, alu_src, imm, rs1, rs2, rd};

  function automatic logic [53:0] exp_of(input vec_t v);
    return {v.ill, v.ctrl, v.src, v.imm, v.instr[19:15], v.instr[24:20], v.instr[11:7]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    int idx, c;
    int q[$];
    logic stalled_prev;
    logic [53:0] snap;

    tbl[0]  = '{32'h00500093, 1'b0, C_ADD,  1'b1, 32'h00000005}; // addi x1,x0,5
    tbl[1]  = '{32'h402081B3, 1'b0, C_SUB,  1'b0, 32'h00000000}; // sub x3,x1,x2
    tbl[2]  = '{32'hFE208EE3, 1'b0, C_BEQ,  1'b0, 32'hFFFFFFFC}; // beq x1,x2,-4
    tbl[3]  = '{32'h40335293, 1'b0, C_SRA,  1'b1, 32'h00000403}; // srai x5,x6,3
    tbl[4]  = '{32'hFFFFFFFF, 1'b1, C_ADD,  1'b0, 32'h00000000}; // bad opcode
    tbl[5]  = '{32'h123452B7, 1'b0, C_ADD,  1'b1, 32'h12345000}; // lui
    tbl[6]  = '{32'h0020A423, 1'b0, C_ADD,  1'b1, 32'h00000008}; // sw x2,8(x1)
    tbl[7]  = '{32'hFF9FF0EF, 1'b0, C_ADD,  1'b1, 32'hFFFFFFF8}; // jal x1,-8
    tbl[8]  = '{32'h0041F863, 1'b0, C_BGEU, 1'b0, 32'h00000010}; // bgeu x3,x4,16
    tbl[9]  = '{32'h0041A863, 1'b1, C_ADD,  1'b0, 32'h00000000}; // branch funct3 010
    tbl[10] = '{32'h802081B3, 1'b1, C_ADD,  1'b0, 32'h00000000}; // bad funct7
    tbl[11] = '{32'h0062B233, 1'b0, C_SLTU, 1'b0, 32'h00000000}; // sltu x4,x5,x6
    tbl[12] = '{32'hFFC12383, 1'b0, C_ADD,  1'b1, 32'hFFFFFFFC}; // lw x7,-4(x2)
    tbl[13] = '{32'h00001097, 1'b0, C_ADD,  1'b1, 32'h00001000}; // auipc x1,1
    tbl[14] = '{32'hFFF1C113, 1'b0, C_XOR,  1'b1, 32'hFFFFFFFF}; // xori x2,x3,-1
    tbl[15] = '{32'h403150B3, 1'b0, C_SRA,  1'b0, 32'h00000000}; // sra x1,x2,x3
    tbl[16] = '{32'h00008067, 1'b0, C_ADD,  1'b1, 32'h00000000}; // jalr x0,0(x1)

    rst = 1'b1; in_valid = 1'b0; instr = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_fields", 64'(act), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", 64'(in_ready), 64'(1));

    // Back-to-back decode table at full throughput.
    for (int i = 0; i < NVEC; i++) begin
      in_valid = 1'b1;
      instr    = tbl[i].instr;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(1));
      check($sformatf("vec%0d_fields", i), 64'(act), 64'(exp_of(tbl[i])));
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("drained_after_table", 64'(out_valid), 64'(0));

    // Four-instruction stream with out_ready low on cycles 2-4.
    idx = 0; c = 0; stalled_prev = 1'b0; snap = '0;
    while ((idx < 4 || q.size() > 0) && c < 30) begin
      out_ready = !(c >= 2 && c <= 4);
      in_valid  = (idx < 4);
      instr     = tbl[(idx < 4) ? idx : 0].instr;
      #1;
      if (stalled_prev) check($sformatf("stall_hold_c%0d", c), 64'({out_valid, act}), 64'({1'b1, snap}));
`ifdef DECODE_SKID_EN
      if (c == 2) check("stream_in_ready_c2", 64'(in_ready), 64'(1));
`else
      if (c == 2) check("stream_in_ready_c2", 64'(in_ready), 64'(0));
`endif
      if (c == 3) check("stream_in_ready_c3", 64'(in_ready), 64'(0));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check($sformatf("stream_dup_c%0d", c), 64'(1), 64'(0));
        end else begin
          check($sformatf("stream_order_c%0d", c), 64'(act), 64'(exp_of(tbl[q.pop_front()])));
        end
      end
      stalled_prev = out_valid && !out_ready;
      snap = act;
      if (in_valid && in_ready) begin
        q.push_back(idx);
        idx++;
      end
      @(negedge clk);
      c++;
    end
    if (c >= 30) check("stream_timeout", 64'(c), 64'(0));
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("stream_drained", 64'(out_valid), 64'(0));

    // Flush while holding a stalled entry, with a competing accept.
    out_ready = 1'b0; in_valid = 1'b1; instr = tbl[4].instr;
    @(negedge clk);
    check("flush_pre_hold", 64'({out_valid, act}), 64'({1'b1, exp_of(tbl[4])}));
    flush = 1'b1; in_valid = 1'b1; instr = tbl[5].instr;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_stalled", 64'(out_valid), 64'(0));
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_no_ghost", 64'(out_valid), 64'(0));

    // Flush beats an accept that would otherwise refill the slot.
    in_valid = 1'b1; instr = tbl[6].instr;
    @(negedge clk);
    flush = 1'b1; instr = tbl[7].instr;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_vs_accept", 64'(out_valid), 64'(0));
    in_valid = 1'b1; instr = tbl[8].instr;
    @(negedge clk);
    in_valid = 1'b0;
    check("after_flush_decode", 64'({out_valid, act}), 64'({1'b1, exp_of(tbl[8])}));

    // Asynchronous reset mid-stream while an entry is held.
    out_ready = 1'b0; in_valid = 1'b1; instr = tbl[2].instr;
    @(negedge clk);
    check("rst_pre_hold", 64'(out_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'(0));
    check("async_rst_fields", 64'(act), 64'(0));
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_release_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    check("rst_no_partial", 64'(out_valid), 64'(0));
    out_ready = 1'b1; in_valid = 1'b1; instr = tbl[3].instr;
    @(negedge clk);
    in_valid = 1'b0;
    check("resume_decode", 64'({out_valid, act}), 64'({1'b1, exp_of(tbl[3])}));
    @(negedge clk);
    check("resume_drained", 64'(out_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
